debounce_ctrl: RTL and testbench
================================

# debounce_ctrl

Multi-channel switch debounce controller. It owns one shared periodic tick generator (10 ms at 100 MHz by default) and uses that tick to sequence an independent per-channel debounce state machine. It sits between the raw board switches/buttons and user logic, and delivers a clean level per channel plus single-cycle rise and fall event pulses.

## Interface
Parameters:
- N_CH, default 4: number of independent input channels.
- TICK_DIV, default 1000000: clock cycles per tick. The tick counter counts 0..TICK_DIV-1.
- STABLE_TICKS, default 3: number of consecutive ticks the input must stay stable before the output changes. Must be ≥1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- sw_in, input, N_CH: raw asynchronous switch inputs.
- db_level, output, N_CH: debounced level.
- rise_pulse, output, N_CH: one-cycle pulse when db_level goes 0→1.
- fall_pulse, output, N_CH: one-cycle pulse when db_level goes 1→0.
- tick_out, output, 1: the shared tick, exported for other timers.

## Operation
- Each sw_in bit passes through a 2-flop synchronizer (reset value 0). The synchronizer output, sync[i], feeds the FSM.
- The tick generator increments every cycle. When count == TICK_DIV-1 it asserts tick for one cycle and wraps to 0.
- Per-channel FSM states: ZERO, WAIT1, ONE, WAIT0. Each channel has a down-counter cnt of width $clog2(STABLE_TICKS+1).
  - ZERO: if sync=1, load cnt=STABLE_TICKS and go to WAIT1.
  - WAIT1: if sync=0, go to ZERO. This check has priority over the tick.
    - Otherwise, on tick, if cnt==1, go to ONE. Otherwise decrement cnt.
  - ONE: if sync=0, load cnt=STABLE_TICKS and go to WAIT0.
  - WAIT0: if sync=1, go to ONE. This check has priority over the tick.
    - Otherwise, on tick, if cnt==1, go to ZERO. Otherwise decrement cnt.
- db_level[i] = 1 in ONE and WAIT0, and 0 in ZERO and WAIT1. It is registered from the next state.
- rise_pulse[i] is high exactly in the first cycle the FSM is in ONE after coming from WAIT1. A return from WAIT0 to ONE produces no pulse.
- fall_pulse[i] is high exactly in the first cycle in ZERO after coming from WAIT0. A return from WAIT1 to ZERO produces no pulse.
- Channels are fully independent. All channels share the same tick.

## Timing
- Reset values:
  - tick counter = 0 and tick_out = 0.
  - All states = ZERO, all cnt = 0.
  - db_level, rise_pulse, fall_pulse = 0.
  - Synchronizers = 0.
- Input to FSM latency: 2 cycles through the synchronizer.
- Debounce delay, measured from FSM entry into WAIT1/WAIT0 to the output change: between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles. The spread comes from the tick phase.
- Output change is registered. db_level and its pulse appear the cycle after the STABLE_TICKS-th tick is sampled in WAIT1/WAIT0.
- The rise/fall pulse coincides with the first cycle of the new db_level value.
- Simultaneous events:
  - Input reverses in the same cycle as the final tick: the FSM aborts, with no output change and no pulse.
  - Tick in the same cycle as a ZERO→WAIT1 (or ONE→WAIT0) entry: no effect on cnt that cycle.
- Reset mid-operation: reset wins over everything. An in-flight debounce is discarded and no pulse is emitted. The tick phase restarts at 0.
- rise_pulse and fall_pulse are never both high on the same channel.

## Structure
- Package debounce_pkg holds:
  - the state enum db_state_t (ZERO, WAIT1, ONE, WAIT0);
  - the default constants DB_TICK_DIV_DEFAULT=1000000 and DB_STABLE_TICKS_DEFAULT=3.
- Sub-module tick_gen, parameterized by TICK_DIV, with ports clk, reset, tick. It is instantiated once.
- Per-channel FSM, synchronizer and counter are written in a generate loop inside debounce_ctrl.

## Test plan
Bench parameters: N_CH=2, TICK_DIV=4, STABLE_TICKS=3.
1. Hold reset for 5 cycles with sw_in=2'b11 → all outputs 0 during reset. After release, tick_out first pulses in the 4th cycle after reset deasserts.
2. Raise sw_in[0] and hold it → db_level[0] rises after the 3rd tick following WAIT1 entry. rise_pulse[0] is high for exactly 1 cycle. Channel 1 stays 0.
3. Toggle sw_in[0] every 3 cycles for 30 cycles, then hold it at 0 → no rise_pulse, and db_level[0] stays 0 throughout.
4. From the debounced-high state, drop sw_in[0] and hold it → fall_pulse[0] is high for 1 cycle and db_level[0]=0 after 3 ticks. A 1-cycle glitch back to 1 during WAIT0 restarts the count and emits no pulse.
5. Drop sync[0] in the same cycle as the 3rd tick in WAIT1 → the FSM returns to ZERO, with no rise_pulse.
6. Assert reset while channel 0 is in WAIT1 with cnt=1 → after reset, all outputs are 0 and no pulse fires. A fresh press then needs the full 3 ticks.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debounce controller.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int unsigned DB_TICK_DIV_DEFAULT     = 1000000;
    localparam int unsigned DB_STABLE_TICKS_DEFAULT = 3;

    // Width of a counter that must hold 0..n_vals-1, never narrower than one bit.
    function automatic int unsigned db_count_width(input int unsigned n_vals);
        return (n_vals > 1) ? $clog2(n_vals) : 1;
    endfunction

endpackage

// File: rtl/debounce_ctrl_tick_gen.sv
// Free-running divider that emits a registered one-cycle tick every TICK_DIV clocks.
module tick_gen
    import debounce_pkg::*;
#(
    parameter int unsigned TICK_DIV = DB_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW   = db_count_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = (count == LAST) ? '0 : count + CW'(1);
    end

    // tick is registered from the next count so it is high exactly while count == LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_nxt;
            tick  <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-channel switch debouncer: per-channel synchronizer and tick-sequenced FSM sharing one tick.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = DB_TICK_DIV_DEFAULT,
    parameter int unsigned STABLE_TICKS = DB_STABLE_TICKS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            tick_out
);

    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign tick_out = tick;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic             sync_meta;
        logic             sync;
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             rise;
        logic             fall;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_meta <= 1'b0;
                sync      <= 1'b0;
            end else begin
                sync_meta <= sw_in[i];
                sync      <= sync_meta;
            end
        end

        // Input reversal beats the tick in the WAIT states; level and pulses follow the next state.
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= ZERO;
                cnt   <= '0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                case (state)
                    ZERO: begin
                        if (sync) begin
                            state <= WAIT1;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    WAIT1: begin
                        if (!sync) begin
                            state <= ZERO;
                        end else if (tick) begin
                            if (cnt == CNT_ONE) begin
                                state <= ONE;
                                level <= 1'b1;
                                rise  <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end
                    ONE: begin
                        if (!sync) begin
                            state <= WAIT0;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    WAIT0: begin
                        if (sync) begin
                            state <= ONE;
                        end else if (tick) begin
                            if (cnt == CNT_ONE) begin
                                state <= ZERO;
                                level <= 1'b0;
                                fall  <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= ZERO;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign db_level[i]   = level;
        assign rise_pulse[i] = rise;
        assign fall_pulse[i] = fall;
    end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Self-checking bench for debounce_ctrl: directed scenarios plus random toggling against a run-length model.
module tb_debounce_ctrl;

    localparam int unsigned N_CH         = 2;
    localparam int unsigned TICK_DIV     = 4;
    localparam int unsigned STABLE_TICKS = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] sw_in;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic            tick_out;

    always #5 clk = ~clk;

    debounce_ctrl #(
        .N_CH         (N_CH),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
        .db_level   (db_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .tick_out   (tick_out)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference: two-stage input delay, tick phase count, and per channel the run of
    // consecutive cycles where the synchronized input disagrees with the clean level.
    logic [N_CH-1:0] m_s1   = '0;
    logic [N_CH-1:0] m_s2   = '0;
    logic [N_CH-1:0] m_db   = '0;
    logic [N_CH-1:0] m_rise = '0;
    logic [N_CH-1:0] m_fall = '0;
    int              m_phase = 0;
    bit              m_act [N_CH];
    int              m_run [N_CH];

    int unsigned r_cnt [N_CH];
    int unsigned f_cnt [N_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < int'(N_CH); c++) begin
            r_cnt[c] = 0;
            f_cnt[c] = 0;
        end
    endtask

    // One clock: advance the model with pre-edge values, then compare all outputs.
    task automatic step();
        bit tk;
        @(posedge clk);
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_phase = 0;
            for (int c = 0; c < int'(N_CH); c++) begin
                m_act[c] = 1'b0;
                m_run[c] = 0;
            end
        end else begin
            tk     = (m_phase == int'(TICK_DIV) - 1);
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                if (m_s2[c] == m_db[c]) begin
                    m_act[c] = 1'b0;
                end else if (!m_act[c]) begin
                    m_act[c] = 1'b1;
                    m_run[c] = 0;
                end else if (tk) begin
                    m_run[c]++;
                    if (m_run[c] == int'(STABLE_TICKS)) begin
                        m_db[c]  = ~m_db[c];
                        m_act[c] = 1'b0;
                        if (m_db[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                    end
                end
            end
            m_s2    = m_s1;
            m_s1    = sw_in;
            m_phase = (m_phase + 1) % int'(TICK_DIV);
        end
        #1;
        check("db_level",   32'(db_level),   32'(m_db));
        check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        check("tick_out",   32'(tick_out),   32'(m_phase == int'(TICK_DIV) - 1));
        check("rise_fall_excl", 32'(|(rise_pulse & fall_pulse)), 32'(0));
        for (int c = 0; c < int'(N_CH); c++) begin
            r_cnt[c] += int'(rise_pulse[c]);
            f_cnt[c] += int'(fall_pulse[c]);
        end
    endtask

    initial begin
        int  n;
        bit  found;
        bit  hi_seen;
        int  hold [N_CH];

        for (int c = 0; c < int'(N_CH); c++) begin
            m_act[c] = 1'b0;
            m_run[c] = 0;
        end
        clear_counts();

        // 1: reset held with inputs high; tick phase after release
        reset = 1'b1;
        sw_in = 2'b11;
        repeat (5) begin
            step();
            check("t1_outputs_in_reset", 32'({db_level, rise_pulse, fall_pulse, tick_out}), 32'(0));
        end
        sw_in = 2'b00;
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t1_tick_cycle%0d", k), 32'(tick_out), 32'(k == 3));
        end
        repeat (4) step();

        // 2: press channel 0 and hold
        clear_counts();
        sw_in = 2'b01;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            if (db_level[0]) found = 1'b1;
        end
        check("t2_rise_found", 32'(found), 32'(1));
        check("t2_latency_in_window", 32'(n >= 12 && n <= 15), 32'(1));
        repeat (5) step();
        check("t2_rise_count", r_cnt[0], 32'(1));
        check("t2_ch1_quiet", 32'({db_level[1], 1'b0}) | 32'(r_cnt[1]), 32'(0));

        // 4: release with a one-cycle glitch back high during WAIT0
        clear_counts();
        sw_in = 2'b00;
        repeat (6) step();
        check("t4_still_high_pre_glitch", 32'(db_level[0]), 32'(1));
        sw_in = 2'b01;
        step();
        sw_in = 2'b00;
        n = 0;
        found = 1'b0;
        while (!found && n < 60) begin
            step();
            n++;
            if (!db_level[0]) found = 1'b1;
        end
        check("t4_fall_found", 32'(found), 32'(1));
        check("t4_restart_latency", 32'(n >= 12 && n <= 15), 32'(1));
        repeat (5) step();
        check("t4_fall_count", f_cnt[0], 32'(1));
        check("t4_no_rise", r_cnt[0], 32'(0));

        // 3: chatter every 3 cycles never settles
        clear_counts();
        hi_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sw_in[0] = ((i / 3) % 2 == 0);
            step();
            hi_seen |= db_level[0];
        end
        sw_in = 2'b00;
        repeat (20) begin
            step();
            hi_seen |= db_level[0];
        end
        check("t3_no_rise", r_cnt[0], 32'(0));
        check("t3_level_low", 32'(hi_seen), 32'(0));

        // 5: input drops exactly on the final tick in WAIT1
        clear_counts();
        sw_in = 2'b01;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            if (m_act[0] && m_run[0] == 2 && m_phase == 1) found = 1'b1;
        end
        check("t5_alignment_found", 32'(found), 32'(1));
        sw_in = 2'b00;
        repeat (12) step();
        check("t5_no_rise", r_cnt[0], 32'(0));
        check("t5_level_low", 32'(db_level[0]), 32'(0));

        // 6: reset while WAIT1 has one tick left, then a fresh press
        clear_counts();
        sw_in = 2'b01;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            if (m_act[0] && m_run[0] == 2) found = 1'b1;
        end
        check("t6_wait1_found", 32'(found), 32'(1));
        sw_in = 2'b00;
        reset = 1'b1;
        step();
        check("t6_outputs_after_reset", 32'({db_level, rise_pulse, fall_pulse, tick_out}), 32'(0));
        reset = 1'b0;
        repeat (3) step();
        check("t6_no_pulse", r_cnt[0] + f_cnt[0], 32'(0));
        sw_in = 2'b01;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            if (db_level[0]) found = 1'b1;
        end
        check("t6_full_latency", 32'(n), 32'(13));

        // Random hold lengths on both channels
        for (int c = 0; c < int'(N_CH); c++) hold[c] = 0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (hold[c] == 0) begin
                    sw_in[c] = $urandom_range(1, 0) == 1;
                    hold[c]  = int'($urandom_range(20, 1));
                end
                hold[c]--;
            end
            step();
        end
        sw_in = 2'b00;
        repeat (20) step();
        check("final_level_low", 32'(db_level), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
